boolean_lut_sweep: RTL and testbench
====================================

BOOLEAN_LUT_SWEEP -- requirements
Module: boolean_lut_sweep

Interface
REQ-001 Parameter: N_IN, default 4, number of boolean inputs (legal 2..8).
REQ-002 Parameter: TT_W, default 2**N_IN, truth-table width (derived, SHALL NOT be overridden).
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: cfg_load  input  1  shift one truth-table bit this cycle.
REQ-006 Port: cfg_bit  input  1  truth-table bit shifted in.
REQ-007 Port: eval_valid  input  1  evaluation request.
REQ-008 Port: eval_in  input  N_IN  input vector {A,B,C,D,...}, MSB = A.
REQ-009 Port: eval_ready  output  1  evaluation request accepted this cycle.
REQ-010 Port: y_valid  output  1  y qualified, one-cycle pulse per result.
REQ-011 Port: y  output  1  function value.
REQ-012 Port: sweep_start  input  1  start exhaustive sweep.
REQ-013 Port: sweep_busy  output  1  sweep in progress.
REQ-014 Port: sweep_done  output  1  one-cycle pulse after last minterm.
REQ-015 Port: minterm_idx  output  N_IN  index of current y during sweep.
REQ-016 Port: ones_count  output  N_IN+1  count of y=1 results in current or last sweep.

Function
REQ-017 Truth table tt[TT_W-1:0]: on cfg_load in IDLE, tt <= {tt[TT_W-2:0], cfg_bit}; first bit loaded after TT_W shifts is tt[TT_W-1].
REQ-018 cfg_load outside IDLE SHALL be ignored; tt unchanged.
REQ-019 eval_ready = (state==IDLE) && !cfg_load && !sweep_start, combinational.
REQ-020 Accept on eval_valid && eval_ready; next cycle y = tt[eval_in], y_valid = 1; latency exactly 1 cycle, throughput 1 per cycle.
REQ-021 FSM states: IDLE, SWEEP, DONE.
REQ-022 IDLE -> SWEEP on sweep_start; idx cleared to 0, ones_count cleared to 0; sweep_start has priority over eval_valid and cfg_load.
REQ-023 SWEEP: each cycle y = tt[idx], minterm_idx = idx, y_valid = 1, ones_count += y, idx += 1; sweep_busy = 1.
REQ-024 SWEEP -> DONE after idx = TT_W-1 presented; idx SHALL NOT wrap into a second pass.
REQ-025 DONE: sweep_done = 1 for exactly one cycle, y_valid = 0, ones_count holds final value; then -> IDLE.
REQ-026 sweep_start while in SWEEP or DONE SHALL be ignored.
REQ-027 ones_count holds until the next sweep_start; all-ones table yields TT_W without overflow.
REQ-028 y, minterm_idx hold last value when y_valid = 0.

Reset
REQ-029 rst_n low asynchronously: state = IDLE, tt = 0, y = 0, y_valid = 0, sweep_busy = 0, sweep_done = 0, minterm_idx = 0, ones_count = 0.
REQ-030 Reset mid-sweep SHALL abort with no sweep_done pulse; first post-reset cycle is IDLE.

Configuration
REQ-031 Macro LUT_SWEEP_EN defined: sweep engine (REQ-021..REQ-027) present.
REQ-032 LUT_SWEEP_EN undefined: no sweep logic; sweep_start ignored; sweep_busy, sweep_done, minterm_idx, ones_count tied 0; eval path unchanged.

Verification (N_IN=4, LUT_SWEEP_EN defined)
REQ-033 Reset then shift 16'hA5C3 MSB-first over 16 cfg_load cycles; eval_in=0 -> y=1, eval_in=2 -> y=0, eval_in=15 -> y=1, each 1 cycle after accept.
REQ-034 sweep_start at cycle 0 -> y_valid cycles 1..16 with minterm_idx 0..15, sweep_done at cycle 17, ones_count = 8.
REQ-035 sweep_start and eval_valid same cycle in IDLE -> eval_ready = 0, sweep begins, no eval result.
REQ-036 cfg_load pulses during SWEEP -> tt unchanged; rerun sweep gives ones_count = 8.
REQ-037 rst_n low at cycle 7 of sweep -> all outputs 0 immediately, no sweep_done, tt = 0.
REQ-038 tt = 16'hFFFF, sweep -> ones_count = 16 (5'b10000).

Source files
------------

// File: rtl/boolean_lut_sweep_if.sv
// boolean_lut_sweep_if: config, evaluation handshake and sweep-status signals of boolean_lut_sweep
interface boolean_lut_sweep_if #(parameter int N_IN = 4);
  logic cfg_load, cfg_bit, eval_valid, eval_ready, y_valid, y, sweep_start, sweep_busy, sweep_done;
  logic [N_IN-1:0] eval_in, minterm_idx;
  logic [N_IN:0] ones_count;
  modport master(
    output cfg_load, cfg_bit, eval_valid, eval_in, sweep_start,
    input eval_ready, y_valid, y, sweep_busy, sweep_done, minterm_idx, ones_count
  );
  modport slave(
    input cfg_load, cfg_bit, eval_valid, eval_in, sweep_start,
    output eval_ready, y_valid, y, sweep_busy, sweep_done, minterm_idx, ones_count
  );
endinterface

// File: rtl/boolean_lut_sweep.sv
// boolean_lut_sweep: shift-loaded N_IN-input truth table with 1-cycle lookup; the exhaustive
// sweep engine is built only when LUT_SWEEP_EN is defined.
module boolean_lut_sweep #(
  parameter int N_IN = 4,
  localparam int TT_W = 2**N_IN
) (
  input logic clk,
  input logic rst_n,
  boolean_lut_sweep_if.slave bus
);
  logic [TT_W-1:0] tt;
`ifdef LUT_SWEEP_EN
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state;
  logic [N_IN-1:0] idx;
  assign bus.eval_ready = (state == IDLE) && !bus.cfg_load && !bus.sweep_start;
  // minterm 0 is issued on the start edge so results appear one cycle after sweep_start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tt <= '0;
      idx <= '0;
      bus.y <= 1'b0;
      bus.y_valid <= 1'b0;
      bus.sweep_busy <= 1'b0;
      bus.sweep_done <= 1'b0;
      bus.minterm_idx <= '0;
      bus.ones_count <= '0;
    end else begin
      bus.y_valid <= 1'b0;
      bus.sweep_done <= 1'b0;
      case (state)
        IDLE:
          if (bus.sweep_start) begin
            state <= SWEEP;
            idx <= N_IN'(1);
            bus.y <= tt[0];
            bus.y_valid <= 1'b1;
            bus.minterm_idx <= '0;
            bus.ones_count <= (N_IN+1)'(tt[0]);
            bus.sweep_busy <= 1'b1;
          end else if (bus.cfg_load) tt <= {tt[TT_W-2:0], bus.cfg_bit};
          else if (bus.eval_valid) begin
            bus.y <= tt[bus.eval_in];
            bus.y_valid <= 1'b1;
          end
        SWEEP: begin
          bus.y <= tt[idx];
          bus.y_valid <= 1'b1;
          bus.minterm_idx <= idx;
          bus.ones_count <= bus.ones_count + (N_IN+1)'(tt[idx]);
          idx <= idx + 1'b1;
          if (&idx) state <= DONE;
        end
        DONE: begin
          bus.sweep_done <= 1'b1;
          bus.sweep_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`else
  assign bus.eval_ready = !bus.cfg_load;
  assign bus.sweep_busy = 1'b0;
  assign bus.sweep_done = 1'b0;
  assign bus.minterm_idx = '0;
  assign bus.ones_count = '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tt <= '0;
      bus.y <= 1'b0;
      bus.y_valid <= 1'b0;
    end else begin
      bus.y_valid <= 1'b0;
      if (bus.cfg_load) tt <= {tt[TT_W-2:0], bus.cfg_bit};
      else if (bus.eval_valid) begin
        bus.y <= tt[bus.eval_in];
        bus.y_valid <= 1'b1;
      end
    end
`endif
endmodule

// File: tb/tb_boolean_lut_sweep.sv
// tb_boolean_lut_sweep: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_boolean_lut_sweep;
  localparam int N_IN = 4;
  typedef struct {logic y; logic [N_IN-1:0] idx; logic busy; int cyc;} exp_t;
  typedef struct {int ones; int cyc;} done_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  logic [15:0] tt_model = 16'h0;
  exp_t sb[$];
  done_t dq[$];
  boolean_lut_sweep_if #(.N_IN(N_IN)) bus();
  boolean_lut_sweep #(.N_IN(N_IN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      bus.cfg_load = 1'b1;
      bus.cfg_bit = v[i];
      #1;
      if (i == 15) check("eval_ready_during_cfg", 32'(bus.eval_ready), 0);
      tick();
    end
    bus.cfg_load = 1'b0;
    tt_model = v;
  endtask
  task automatic eval(input logic [N_IN-1:0] a, input logic y_exp);
    bus.eval_valid = 1'b1;
    bus.eval_in = a;
    #1;
    check("eval_ready", 32'(bus.eval_ready), 1);
    sb.push_back('{y_exp, '0, 1'b0, cyc + 1});
    tick();
    bus.eval_valid = 1'b0;
  endtask
  task automatic sweep(input logic [15:0] t, input int ones);
    bus.sweep_start = 1'b1;
    #1;
    check("eval_ready_on_start", 32'(bus.eval_ready), 0);
    for (int i = 0; i < 16; i++) sb.push_back('{t[i], 4'(i), 1'b1, cyc + 1 + i});
    dq.push_back('{ones, cyc + 17});
    tick();
    bus.sweep_start = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (bus.y_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y_valid: got y_valid=1 required no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("y", 32'(bus.y), 32'(e.y));
        check("y_cycle", cyc, e.cyc);
        if (e.busy) begin
          check("minterm_idx", 32'(bus.minterm_idx), 32'(e.idx));
          check("sweep_busy", 32'(bus.sweep_busy), 1);
        end
      end
    end
    if (bus.sweep_done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sweep_done: got sweep_done=1 required 0 (cycle %0d)", cyc);
      end else begin
        done_t d;
        d = dq.pop_front();
        check("ones_count", 32'(bus.ones_count), d.ones);
        check("done_cycle", cyc, d.cyc);
        check("busy_after_done", 32'(bus.sweep_busy), 0);
      end
    end
  end
  initial begin
    bus.cfg_load = 1'b0;
    bus.cfg_bit = 1'b0;
    bus.eval_valid = 1'b0;
    bus.eval_in = '0;
    bus.sweep_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", 32'(bus.y), 0);
    check("rst_y_valid", 32'(bus.y_valid), 0);
    check("rst_busy", 32'(bus.sweep_busy), 0);
    check("rst_done", 32'(bus.sweep_done), 0);
    check("rst_minterm", 32'(bus.minterm_idx), 0);
    check("rst_ones", 32'(bus.ones_count), 0);
    rst_n = 1'b1;
    tick();
    shift(16'hA5C3);
    eval(4'd0, 1'b1);
    eval(4'd2, 1'b0);
    eval(4'd15, 1'b1);
    eval(4'd7, 1'b1);
    eval(4'd8, 1'b1);
    eval(4'd4, 1'b0);
    repeat (2) tick();
`ifdef LUT_SWEEP_EN
    sweep(tt_model, 8);
    repeat (18) tick();
    bus.eval_valid = 1'b1;
    bus.eval_in = 4'd0;
    sweep(tt_model, 8);
    bus.eval_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_load = 1'b1;
      bus.cfg_bit = i[0];
      #1;
      check("eval_ready_in_sweep", 32'(bus.eval_ready), 0);
      tick();
    end
    bus.cfg_load = 1'b0;
    repeat (14) tick();
    sweep(tt_model, 8);
    repeat (18) tick();
    sweep(tt_model, 8);
    repeat (6) tick();
    check("busy_before_reset", 32'(bus.sweep_busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_y", 32'(bus.y), 0);
    check("abort_y_valid", 32'(bus.y_valid), 0);
    check("abort_busy", 32'(bus.sweep_busy), 0);
    check("abort_done", 32'(bus.sweep_done), 0);
    check("abort_minterm", 32'(bus.minterm_idx), 0);
    check("abort_ones", 32'(bus.ones_count), 0);
    sb.delete();
    dq.delete();
    tick();
    rst_n = 1'b1;
    tt_model = 16'h0;
    repeat (20) tick();
    eval(4'd0, 1'b0);
    eval(4'd15, 1'b0);
    repeat (2) tick();
    shift(16'hFFFF);
    sweep(16'hFFFF, 16);
    repeat (18) tick();
`else
    bus.sweep_start = 1'b1;
    #1;
    check("eval_ready_start_ignored", 32'(bus.eval_ready), 1);
    tick();
    bus.sweep_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("off_busy", 32'(bus.sweep_busy), 0);
      check("off_done", 32'(bus.sweep_done), 0);
      check("off_minterm", 32'(bus.minterm_idx), 0);
      check("off_ones", 32'(bus.ones_count), 0);
      tick();
    end
    eval(4'd15, 1'b1);
    repeat (2) tick();
`endif
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    check("done_q_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
